// File: rtl/sw_led_io.sv
// Memory-mapped switch/LED peripheral: synchronised and debounced switches, CPU-writable LEDs,
// and sticky halt/change indicators. Define SW_DEBOUNCE_EN to enable the debounce counter.
module sw_led_io #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        CLOCK_50,
  input  logic        KEY1,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        rd_hit,
  input  logic        halt,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR
);

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_RSVD  = 2'b11
  } mem_cmd_e;

  localparam logic [8:0] ADDR_LED = 9'h100;
  localparam logic [8:0] ADDR_SW  = 9'h140;
  localparam logic [8:0] ADDR_CHG = 9'h141;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  logic [9:0]  sw_s1_q, sw_s2_q, sw_stable_q, sw_stable_d;
  logic [7:0]  led_q, led_d;
  logic        chg_flag_q, chg_flag_d, chg_set, flag_clr;
  logic        halt_led_q;
  logic [15:0] read_data_q, read_data_d;
  logic        rd_hit_q, rd_hit_d;

  // Only the low byte of a store reaches the LED register.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^write_data[15:8];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rd_hit_d    = 1'b0;
    read_data_d = read_data_q;
    led_d       = led_q;
    flag_clr    = 1'b0;
    if (mem_cmd == CMD_READ) begin
      unique case (mem_addr)
        ADDR_SW: begin
          rd_hit_d    = 1'b1;
          read_data_d = {6'b0, sw_stable_q};
        end
        ADDR_CHG: begin
          rd_hit_d    = 1'b1;
          read_data_d = {15'b0, chg_flag_q};
          flag_clr    = 1'b1;
        end
        ADDR_LED: begin
          rd_hit_d    = 1'b1;
          read_data_d = {8'b0, led_q};
        end
        default: ;
      endcase
    end
    if (mem_cmd == CMD_WRITE && mem_addr == ADDR_LED) begin
      led_d = write_data[7:0];
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts consecutive cycles the synchronised vector differs from the accepted one;
  // any return to the accepted value restarts the count.
  always_comb begin
    sw_stable_d = sw_stable_q;
    cnt_d       = '0;
    chg_set     = 1'b0;
    if (sw_s2_q != sw_stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        sw_stable_d = sw_s2_q;
        chg_set     = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY1) begin
    if (!KEY1) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  always_comb begin
    sw_stable_d = sw_s2_q;
    chg_set     = (sw_s2_q != sw_stable_q);
  end
`endif

  // A change accepted on the same edge as a clearing read wins, so no change is lost.
  assign chg_flag_d = chg_set | (chg_flag_q & ~flag_clr);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge KEY1) begin
    if (!KEY1) begin
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      sw_stable_q <= '0;
      led_q       <= '0;
      chg_flag_q  <= 1'b0;
      halt_led_q  <= 1'b0;
      read_data_q <= '0;
      rd_hit_q    <= 1'b0;
    end else begin
      sw_s1_q     <= SW;
      sw_s2_q     <= sw_s1_q;
      sw_stable_q <= sw_stable_d;
      led_q       <= led_d;
      chg_flag_q  <= chg_flag_d;
      halt_led_q  <= halt_led_q | halt;
      read_data_q <= read_data_d;
      rd_hit_q    <= rd_hit_d;
    end
  end

  assign read_data = read_data_q;
  assign rd_hit    = rd_hit_q;
  assign LEDR      = {chg_flag_q, halt_led_q, led_q};

endmodule

// File: tb/tb_sw_led_io.sv
// Randomised scoreboard bench for sw_led_io against a cycle-level behavioural model.
module tb_sw_led_io;

  localparam int DB = 16;
`ifdef SW_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
`else
  localparam int LAT = 3;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        KEY1;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        rd_hit;
  logic        halt;
  logic [9:0]  SW;
  logic [9:0]  LEDR;

  sw_led_io #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK_50  (CLOCK_50),
    .KEY1      (KEY1),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .write_data(write_data),
    .read_data (read_data),
    .rd_hit    (rd_hit),
    .halt      (halt),
    .SW        (SW),
    .LEDR      (LEDR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errors = 0;
  logic done = 1'b0;

  // Reference model state
  logic [15:0] exp_q[$];
  logic [9:0]  m_dly [2];
  logic [9:0]  m_stable, m_seen;
  logic [7:0]  m_led;
  logic        m_flag, m_halt;
  int          m_run;

  // Switch path: raw value seen two edges late; a new value is accepted once it has
  // differed from the accepted one for LAT-2 consecutive edges (one edge without debounce).
  always @(posedge CLOCK_50 or negedge KEY1) begin
    if (!KEY1) begin
      m_dly[0] = '0;
      m_dly[1] = '0;
      m_stable = '0;
      m_led    = '0;
      m_flag   = 1'b0;
      m_halt   = 1'b0;
      m_run    = 0;
    end else begin
      m_seen = m_dly[1];
      if (mem_cmd == 2'b01) begin
        if (mem_addr == 9'h140) exp_q.push_back({6'b0, m_stable});
        else if (mem_addr == 9'h100) exp_q.push_back({8'b0, m_led});
        else if (mem_addr == 9'h141) begin
          exp_q.push_back({15'b0, m_flag});
          m_flag = 1'b0;
        end
      end
      if (mem_cmd == 2'b10 && mem_addr == 9'h100) m_led = write_data[7:0];
      if (halt) m_halt = 1'b1;
      if (m_seen == m_stable) m_run = 0;
      else begin
        m_run = m_run + 1;
        if (m_run == LAT - 2) begin
          m_stable = m_seen;
          m_flag   = 1'b1;
          m_run    = 0;
        end
      end
      m_dly[1] = m_dly[0];
      m_dly[0] = SW;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops an expectation whenever a read is due.
  logic [15:0] m_rd = '0;
  always @(negedge CLOCK_50) begin
    logic [15:0] e;
    if (!KEY1) m_rd = '0;
    check("rd_hit", {31'b0, rd_hit}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (rd_hit) begin
        check("read_data", {16'b0, read_data}, {16'b0, e});
        m_rd = e;
      end
    end else begin
      check("read_data_hold", {16'b0, read_data}, {16'b0, m_rd});
    end
    check("LEDR", {22'b0, LEDR}, {22'b0, m_flag, m_halt, m_led});
    if (done) check("queue_empty", exp_q.size(), 0);
  end

  task automatic step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    @(posedge CLOCK_50);
    #1;
    mem_cmd    = c;
    mem_addr   = a;
    write_data = d;
  endtask

  initial begin
    KEY1 = 1'b0; SW = 10'h3FF; halt = 1'b1;
    mem_cmd = 2'b00; mem_addr = '0; write_data = '0;
    repeat (5) step(2'b00, 9'h0, 16'h0);
    KEY1 = 1'b1;
    step(2'b00, 9'h0, 16'h0);
    halt = 1'b0;
    SW = 10'b0000101001;
    repeat (LAT + 10) step(2'b00, 9'h0, 16'h0);
    step(2'b01, 9'h140, 16'h0);
    step(2'b01, 9'h141, 16'h0);
    step(2'b10, 9'h100, 16'hABCD);
    step(2'b01, 9'h100, 16'h0);
    step(2'b01, 9'h014, 16'h0);
    step(2'b10, 9'h140, 16'h5555);
    step(2'b11, 9'h140, 16'h0);
    step(2'b01, 9'h140, 16'h0);
    step(2'b01, 9'h100, 16'h0);
    step(2'b00, 9'h0, 16'h0);

    // Bounce on SW[0], then hold
    for (int i = 0; i < 12; i++) begin
      SW[0] = ~SW[0];
      repeat (5) step(2'b00, 9'h0, 16'h0);
    end
    SW[0] = 1'b1;
    repeat (LAT + 5) step(2'b01, 9'h140, 16'h0);
    step(2'b01, 9'h141, 16'h0);

    // Clearing read coincides with acceptance of a new vector
    step(2'b01, 9'h141, 16'h0);
    step(2'b00, 9'h0, 16'h0);
    SW = 10'h2C3;
    repeat (LAT - 2) step(2'b00, 9'h0, 16'h0);
    step(2'b01, 9'h141, 16'h0);
    step(2'b00, 9'h0, 16'h0);
    step(2'b01, 9'h141, 16'h0);
    step(2'b00, 9'h0, 16'h0);

    // Asynchronous reset while a new vector is pending
    SW = 10'h155;
    step(2'b00, 9'h0, 16'h0);
    step(2'b00, 9'h0, 16'h0);
    #2 KEY1 = 1'b0;
    repeat (3) step(2'b00, 9'h0, 16'h0);
    KEY1 = 1'b1;
    repeat (LAT + 4) step(2'b01, 9'h140, 16'h0);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      logic [8:0] a;
      case ($urandom_range(0, 3))
        0: a = 9'h100;
        1: a = 9'h140;
        2: a = 9'h141;
        default: a = 9'($urandom_range(0, 511));
      endcase
      step(2'($urandom_range(0, 3)), a, 16'($urandom));
      if ($urandom_range(0, 7) == 0) SW = 10'($urandom);
      else if ($urandom_range(0, 3) == 0) SW[$urandom_range(0, 9)] = ~SW[$urandom_range(0, 9)];
      halt = ($urandom_range(0, 199) == 0);
    end

    halt = 1'b0;
    repeat (3) step(2'b00, 9'h0, 16'h0);
    done = 1'b1;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
